vram_arbiter: RTL and testbench

- Owns the single-port cell RAM that holds the 40x30 snake grid (16x16-pixel cells, 640x480 visible).
- Shares that RAM between the display scan-out, which has hard deadlines and fixed fetch slots, and game-logic writes, which are backpressured through a valid/ready handshake.
- Converts fetched cell codes to 12-bit colour for the display pixel input.
- Provides a whole-grid clear sequencer.

---
 rtl/snake_pkg.sv | 32 +++
 rtl/vram_arbiter_if.sv | 25 ++
 rtl/vram_fetch_sched.sv | 39 +++
 rtl/vram_arbiter.sv | 165 ++++++++++++++++
 tb/tb_vram_arbiter.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared display timing constants, cell types and cell address helper
package snake_pkg;

    localparam int H_TOTAL    = 800;
    localparam int H_VIS      = 640;
    localparam int V_TOTAL    = 525;
    localparam int V_VIS      = 480;
    localparam int CELL_SHIFT = 4;
    localparam int GRID_CELLS = 1200;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        SNAKE = 2'd1,
        FOOD  = 2'd2,
        WALL  = 2'd3
    } cell_t;

    typedef logic [10:0] cell_addr_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } arb_state_t;

    // y*40 + x built from shifts so no multiplier is inferred.
    function automatic cell_addr_t cell_addr(input logic [5:0] y, input logic [5:0] x);
        cell_addr_t yy;
        yy = {5'd0, y};
        return (yy << 5) + (yy << 3) + {5'd0, x};
    endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - game write channel and cell RAM bus
// slave  : arbiter side (accepts writes, drives RAM address/control)
// master : environment side (game logic issuing writes, RAM returning read data)
interface vram_arbiter_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [5:0]  wr_x;
    logic [4:0]  wr_y;
    logic [1:0]  wr_data;
    logic        wr_err;
    logic [10:0] ram_addr;
    logic        ram_we;
    logic [1:0]  ram_wdata;
    logic [1:0]  ram_rdata;

    modport slave (
        input  wr_valid, wr_x, wr_y, wr_data, ram_rdata,
        output wr_ready, wr_err, ram_addr, ram_we, ram_wdata
    );

    modport master (
        output wr_valid, wr_x, wr_y, wr_data, ram_rdata,
        input  wr_ready, wr_err, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/vram_fetch_sched.sv
// rtl/vram_fetch_sched.sv - display fetch-slot decode and fetch address generation
// i_hcount/i_vcount : display counters
// o_fetch           : this cycle is a fetch-decide slot
// o_fetch_addr      : cell address to read in this slot
module vram_fetch_sched
    import snake_pkg::*;
(
    input  logic [9:0]  i_hcount,
    input  logic [9:0]  i_vcount,
    output logic        o_fetch,
    output cell_addr_t  o_fetch_addr
);

    logic       w_slot_cell;
    logic       w_slot_line;
    logic [5:0] w_col;
    logic [5:0] w_row;
    logic [5:0] w_next_row;

    always_comb begin
        // Mid-line slot prefetches the cell to the right of the one on screen.
        w_slot_cell = (i_hcount[3:0] == 4'd13) && (i_hcount < 10'(H_VIS - 16));
        // End-of-line slot prefetches column 0 of the next visible line.
        w_slot_line = (i_hcount == 10'(H_TOTAL - 3)) &&
                      ((i_vcount == 10'(V_TOTAL - 1)) || (i_vcount < 10'(V_VIS - 1)));
        w_next_row  = (i_vcount == 10'(V_TOTAL - 1)) ? 6'd0 :
                      6'((i_vcount + 10'd1) >> CELL_SHIFT);
        if (w_slot_line) begin
            w_col = 6'd0;
            w_row = w_next_row;
        end else begin
            w_col = 6'(i_hcount >> CELL_SHIFT) + 6'd1;
            w_row = 6'(i_vcount >> CELL_SHIFT);
        end
        o_fetch      = w_slot_cell | w_slot_line;
        o_fetch_addr = cell_addr(w_row, w_col);
    end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - cell RAM arbiter: display fetch, game writes, grid clear, palette
// clk25, rst_n     : pixel clock, asynchronous active-low reset
// hcount, vcount   : display counters
// pixel_rgb        : registered colour for the previous cycle's pixel
// clear_req, busy  : grid clear request pulse / clear in progress
// bus (slave)      : game write handshake + RAM address/we/wdata/rdata
// VRAM_GRID_LINES_EN : when defined, draws 12'h333 grid lines on cell borders
module vram_arbiter
    import snake_pkg::*;
#(
    parameter int          GRID_W      = 40,
    parameter int          GRID_H      = 30,
    parameter logic [11:0] COLOR_EMPTY = 12'h000,
    parameter logic [11:0] COLOR_SNAKE = 12'h0F0,
    parameter logic [11:0] COLOR_FOOD  = 12'hF00,
    parameter logic [11:0] COLOR_WALL  = 12'hFFF
)(
    input  logic        clk25,
    input  logic        rst_n,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    output logic [11:0] pixel_rgb,
    input  logic        clear_req,
    output logic        busy,
    vram_arbiter_if.slave bus
);

    arb_state_t  r_state;
    arb_state_t  w_state_nxt;
    logic        r_run;
    cell_addr_t  r_sweep;
    cell_addr_t  r_ram_addr;
    logic        r_ram_we;
    logic [1:0]  r_ram_wdata;
    logic        r_wr_err;
    logic        r_fetch_d1;
    cell_t       r_next_cell;
    cell_t       r_cur_cell;
    logic [11:0] r_pixel;

    logic        w_fetch;
    cell_addr_t  w_fetch_addr;
    logic        w_wr_ready;
    logic        w_busy;
    logic        w_accept;
    logic        w_clr_issue;
    logic        w_in_range;
    cell_addr_t  w_wr_addr;
    logic        w_visible;
    logic [11:0] w_color;

    vram_fetch_sched u_sched (
        .i_hcount     (hcount),
        .i_vcount     (vcount),
        .o_fetch      (w_fetch),
        .o_fetch_addr (w_fetch_addr)
    );

    assign w_in_range = (bus.wr_x < 6'(GRID_W)) && (bus.wr_y < 5'(GRID_H));
    assign w_wr_addr  = cell_addr({1'b0, bus.wr_y}, bus.wr_x);

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (clear_req) w_state_nxt = ST_CLEAR;
            ST_CLEAR: if (w_clr_issue && (r_sweep == 11'(GRID_CELLS - 1))) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // r_run keeps wr_ready low while reset is held and for the first cycle after.
    always_comb begin
        w_wr_ready  = 1'b0;
        w_busy      = 1'b0;
        w_clr_issue = 1'b0;
        case (r_state)
            ST_IDLE:  w_wr_ready = r_run & ~w_fetch;
            ST_CLEAR: begin
                w_busy      = 1'b1;
                w_clr_issue = ~w_fetch;
            end
            default: ;
        endcase
        w_accept = w_wr_ready & bus.wr_valid;
    end

    // RAM port: fetch slots win, then clear sweep, then game writes.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_run       <= 1'b0;
            r_sweep     <= '0;
            r_ram_addr  <= '0;
            r_ram_we    <= 1'b0;
            r_ram_wdata <= 2'd0;
            r_wr_err    <= 1'b0;
        end else begin
            r_run    <= 1'b1;
            r_ram_we <= 1'b0;
            r_wr_err <= 1'b0;
            if (r_state == ST_IDLE) r_sweep <= '0;
            else if (w_clr_issue)   r_sweep <= r_sweep + 11'd1;
            if (w_fetch) begin
                r_ram_addr <= w_fetch_addr;
            end else if (w_clr_issue) begin
                r_ram_addr  <= r_sweep;
                r_ram_we    <= 1'b1;
                r_ram_wdata <= EMPTY;
            end else if (w_accept) begin
                if (w_in_range) begin
                    r_ram_addr  <= w_wr_addr;
                    r_ram_we    <= 1'b1;
                    r_ram_wdata <= bus.wr_data;
                end else begin
                    r_wr_err <= 1'b1;
                end
            end
        end
    end

    // Read data belongs to the fetch decided two cycles back; the cell becomes
    // current at the last pixel of the preceding cell.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_d1  <= 1'b0;
            r_next_cell <= EMPTY;
            r_cur_cell  <= EMPTY;
        end else begin
            r_fetch_d1 <= w_fetch;
            if (r_fetch_d1)              r_next_cell <= cell_t'(bus.ram_rdata);
            if (hcount[3:0] == 4'd15)    r_cur_cell  <= r_next_cell;
        end
    end

    always_comb begin
        w_visible = (hcount < 10'(H_VIS)) && (vcount < 10'(V_VIS));
        case (r_cur_cell)
            EMPTY:   w_color = COLOR_EMPTY;
            SNAKE:   w_color = COLOR_SNAKE;
            FOOD:    w_color = COLOR_FOOD;
            default: w_color = COLOR_WALL;
        endcase
`ifdef VRAM_GRID_LINES_EN
        if ((hcount[3:0] == 4'd0) || (vcount[3:0] == 4'd0)) w_color = 12'h333;
`endif
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) r_pixel <= 12'h000;
        else        r_pixel <= w_visible ? w_color : 12'h000;
    end

    assign pixel_rgb     = r_pixel;
    assign busy          = w_busy;
    assign bus.wr_ready  = w_wr_ready;
    assign bus.wr_err    = r_wr_err;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_we    = r_ram_we;
    assign bus.ram_wdata = r_ram_wdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed self-checking bench for vram_arbiter
module tb_vram_arbiter;

    logic        clk25 = 1'b0;
    logic        rst_n;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic [11:0] pixel_rgb;
    logic        clear_req;
    logic        busy;
    logic        row0_food;
    logic [1:0]  mem [0:2047];

    int errors = 0;
    int checks = 0;

    vram_arbiter_if bus();

    vram_arbiter dut (
        .clk25     (clk25),
        .rst_n     (rst_n),
        .hcount    (hcount),
        .vcount    (vcount),
        .pixel_rgb (pixel_rgb),
        .clear_req (clear_req),
        .busy      (busy),
        .bus       (bus)
    );

    always #5 clk25 = ~clk25;

    always @(posedge clk25) begin
        if (!rst_n) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 2'd0;
        end else if (bus.ram_we) begin
            mem[bus.ram_addr] <= bus.ram_wdata;
        end
    end

    assign bus.ram_rdata = (row0_food && (bus.ram_addr < 11'd40)) ? 2'd2 : mem[bus.ram_addr];

    task automatic report(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic is_fetch(input int h, input int v);
        return (((h % 16) == 13) && (h < 624)) || ((h == 797) && ((v == 524) || (v < 479)));
    endfunction

    function automatic logic [11:0] exp_line0(input int h, input int v);
        if (h >= 640 || v >= 480) return 12'h000;
`ifdef VRAM_GRID_LINES_EN
        if ((h % 16) == 0 || (v % 16) == 0) return 12'h333;
`endif
        return 12'hF00;
    endfunction

    task automatic advance();
        if (hcount == 10'd799) begin
            hcount = 10'd0;
            vcount = (vcount == 10'd524) ? 10'd0 : vcount + 10'd1;
        end else begin
            hcount = hcount + 10'd1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw;
        int extra;
        int ph;
        int pv;
        logic pchk;
        logic pbusy;
        logic pfetch;
        logic re_req;
        logic [11:0] exp_px;

        rst_n = 1'b0; hcount = 10'd0; vcount = 10'd0; clear_req = 1'b0; row0_food = 1'b0;
        bus.wr_valid = 1'b0; bus.wr_x = 6'd0; bus.wr_y = 5'd0; bus.wr_data = 2'd0;
        repeat (3) @(posedge clk25);
        @(negedge clk25);
        checks++; if (pixel_rgb !== 12'h000) report("rst_pixel", pixel_rgb, 12'h000);
        checks++; if (bus.wr_ready !== 1'b0) report("rst_wr_ready", bus.wr_ready, 0);
        checks++; if (bus.wr_err !== 1'b0) report("rst_wr_err", bus.wr_err, 0);
        checks++; if (busy !== 1'b0) report("rst_busy", busy, 0);
        checks++; if (bus.ram_addr !== 11'd0) report("rst_ram_addr", bus.ram_addr, 0);
        checks++; if (bus.ram_we !== 1'b0) report("rst_ram_we", bus.ram_we, 0);
        checks++; if (bus.ram_wdata !== 2'd0) report("rst_ram_wdata", bus.ram_wdata, 0);
        @(posedge clk25); #1 rst_n = 1'b1;
        @(posedge clk25); #1;

        hcount = 10'd100; vcount = 10'd0;
        bus.wr_valid = 1'b1; bus.wr_x = 6'd5; bus.wr_y = 5'd2; bus.wr_data = 2'd1;
        @(negedge clk25);
        checks++; if (bus.wr_ready !== 1'b1) report("w1_ready", bus.wr_ready, 1);
        @(posedge clk25); #1 bus.wr_valid = 1'b0; hcount = 10'd101;
        @(negedge clk25);
        checks++; if (bus.ram_addr !== 11'd85) report("w1_addr", bus.ram_addr, 85);
        checks++; if (bus.ram_we !== 1'b1) report("w1_we", bus.ram_we, 1);
        checks++; if (bus.ram_wdata !== 2'd1) report("w1_wdata", bus.ram_wdata, 1);
        checks++; if (bus.wr_err !== 1'b0) report("w1_err", bus.wr_err, 0);

        hcount = 10'd13; vcount = 10'd48;
        bus.wr_valid = 1'b1; bus.wr_x = 6'd7; bus.wr_y = 5'd3; bus.wr_data = 2'd3;
        @(negedge clk25);
        checks++; if (bus.wr_ready !== 1'b0) report("w2_ready_slot", bus.wr_ready, 0);
        @(posedge clk25); #1 hcount = 10'd14;
        @(negedge clk25);
        checks++; if (bus.wr_ready !== 1'b1) report("w2_ready_after", bus.wr_ready, 1);
        checks++; if (bus.ram_addr !== 11'd121) report("w2_fetch_addr", bus.ram_addr, 121);
        checks++; if (bus.ram_we !== 1'b0) report("w2_fetch_we", bus.ram_we, 0);
        @(posedge clk25); #1 bus.wr_valid = 1'b0; hcount = 10'd15;
        @(negedge clk25);
        checks++; if (bus.ram_addr !== 11'd127) report("w2_addr", bus.ram_addr, 127);
        checks++; if (bus.ram_we !== 1'b1) report("w2_we", bus.ram_we, 1);
        checks++; if (bus.ram_wdata !== 2'd3) report("w2_wdata", bus.ram_wdata, 3);

        for (int t = 0; t < 2; t++) begin
            @(posedge clk25); #1 hcount = 10'd200; vcount = 10'd0;
            bus.wr_valid = 1'b1; bus.wr_data = 2'd1;
            bus.wr_x = (t == 0) ? 6'd40 : 6'd0;
            bus.wr_y = (t == 0) ? 5'd0 : 5'd30;
            @(negedge clk25);
            checks++; if (bus.wr_ready !== 1'b1) report("oor_ready", bus.wr_ready, 1);
            @(posedge clk25); #1 bus.wr_valid = 1'b0; hcount = 10'd201;
            @(negedge clk25);
            checks++; if (bus.ram_we !== 1'b0) report("oor_we", bus.ram_we, 0);
            checks++; if (bus.wr_err !== 1'b1) report("oor_err", bus.wr_err, 1);
            @(posedge clk25); #1 hcount = 10'd202;
            @(negedge clk25);
            checks++; if (bus.wr_err !== 1'b0) report("oor_err_once", bus.wr_err, 0);
        end

        row0_food = 1'b1;
        pchk = 1'b0; ph = 0; pv = 0;
        for (int k = 0; k < 804; k++) begin
            @(posedge clk25); #1;
            if (k < 3) begin
                hcount = 10'(797 + k); vcount = 10'd524;
            end else if (k < 803) begin
                hcount = 10'(k - 3); vcount = 10'd0;
            end else begin
                hcount = 10'd0; vcount = 10'd1;
            end
            @(negedge clk25);
            if (pchk) begin
                exp_px = exp_line0(ph, pv);
                checks++; if (pixel_rgb !== exp_px) report("line0_pixel", pixel_rgb, exp_px);
            end
            pchk = (k >= 3) && (k < 803);
            ph = int'(hcount); pv = int'(vcount);
        end
        row0_food = 1'b0;

`ifdef VRAM_GRID_LINES_EN
        @(posedge clk25); #1 hcount = 10'd16; vcount = 10'd5;
        @(posedge clk25); #1 hcount = 10'd17;
        @(negedge clk25);
        checks++; if (pixel_rgb !== 12'h333) report("grid_16_5", pixel_rgb, 12'h333);
`endif

        @(posedge clk25); #1 hcount = 10'd0; vcount = 10'd100; clear_req = 1'b1;
        pfetch = is_fetch(int'(hcount), int'(vcount)); pbusy = 1'b0;
        nw = 0; re_req = 1'b0;
        for (int c = 0; c < 3000 && nw < 1200; c++) begin
            @(posedge clk25); #1 clear_req = 1'b0; advance();
            if (nw == 600 && !re_req) begin clear_req = 1'b1; re_req = 1'b1; end
            @(negedge clk25);
            if (bus.ram_we) begin
                checks++; if (int'(bus.ram_addr) !== nw) report("clr_addr", bus.ram_addr, nw);
                checks++; if (bus.ram_wdata !== 2'd0) report("clr_wdata", bus.ram_wdata, 0);
                checks++; if (pfetch !== 1'b0) report("clr_not_slot", pfetch, 0);
                checks++; if (pbusy !== 1'b1) report("clr_busy", pbusy, 1);
                nw++;
            end
            if (nw == 100 && busy) begin
                checks++; if (bus.wr_ready !== 1'b0) report("clr_wr_ready", bus.wr_ready, 0);
            end
            pbusy = busy;
            pfetch = is_fetch(int'(hcount), int'(vcount));
        end
        checks++; if (nw !== 1200) report("clr_count", nw, 1200);
        checks++; if (busy !== 1'b0) report("clr_busy_drop", busy, 0);
        extra = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk25); #1 advance();
            @(negedge clk25);
            if (bus.ram_we) extra++;
        end
        checks++; if (extra !== 0) report("clr_no_extra", extra, 0);

        @(posedge clk25); #1 hcount = 10'd0; vcount = 10'd200; clear_req = 1'b1;
        nw = 0;
        for (int c = 0; c < 1000 && nw < 300; c++) begin
            @(posedge clk25); #1 clear_req = 1'b0; advance();
            @(negedge clk25);
            if (bus.ram_we) nw++;
        end
        checks++; if (nw !== 300) report("abort_count", nw, 300);
        checks++; if (busy !== 1'b1) report("abort_busy_before", busy, 1);
        @(posedge clk25); #1 rst_n = 1'b0;
        @(negedge clk25);
        checks++; if (busy !== 1'b0) report("abort_busy", busy, 0);
        checks++; if (bus.ram_we !== 1'b0) report("abort_we", bus.ram_we, 0);
        @(posedge clk25); #1 rst_n = 1'b1;
        @(posedge clk25); #1 hcount = 10'd100; vcount = 10'd0;
        bus.wr_valid = 1'b1; bus.wr_x = 6'd2; bus.wr_y = 5'd0; bus.wr_data = 2'd1;
        @(negedge clk25);
        checks++; if (bus.wr_ready !== 1'b1) report("abort_ready", bus.wr_ready, 1);
        checks++; if (busy !== 1'b0) report("abort_idle", busy, 0);
        @(posedge clk25); #1 bus.wr_valid = 1'b0; hcount = 10'd101;
        @(negedge clk25);
        checks++; if (bus.ram_we !== 1'b1) report("abort_wr_we", bus.ram_we, 1);
        checks++; if (bus.ram_addr !== 11'd2) report("abort_wr_addr", bus.ram_addr, 2);
        @(posedge clk25); #1 hcount = 10'd102;
        @(negedge clk25);
        checks++; if (busy !== 1'b0) report("abort_stays_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
